// File: rtl/div_16_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_WIDTH : default operand/result width (also the iteration count)
//   DIV_CNT_W : width of the iteration counter, large enough to hold DIV_WIDTH
//   state_t   : controller states IDLE -> CALC -> DONE -> IDLE
package div_16_seq_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_16_seq_sub_17.sv
// Ripple subtractor built from a chain of full adders: diff = a + ~b + 1.
//   full_adder : one-bit sum/carry cell
//   sub_17     : N-bit subtractor (N = 17 for the 16-bit divider)
//     a, b   : N-bit unsigned operands
//     diff   : a - b modulo 2**N
//     borrow : 1 when a < b (inverted carry-out of the adder chain)

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module sub_17 #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    // carry[0] = 1 supplies the "+1" of the two's-complement negation.
    logic [N:0] carry;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (~b[i]),
            .ci (carry[i]),
            .s  (diff[i]),
            .co (carry[i+1])
        );
    end

    // No carry out of a + ~b + 1 means the subtraction wrapped.
    assign borrow = ~carry[N];
endmodule

// File: rtl/div_16_seq.sv
// Sequential unsigned restoring divider, one subtract-and-shift step per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; in_ready is high only in IDLE
//   dividend, divisor    : operands, sampled on accept
//   out_valid / out_ready: result handshake; out_valid is high only in DONE
//   quotient, remainder  : registered result, held until the next result
//   div_by_zero          : result came from a zero divisor
//   state_dbg            : current controller state
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid may not be ignored except while ready is low;
// data/results are stable while valid is high and ready is low.
module div_16_seq
    import div_16_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output state_t           state_dbg
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;        // partial remainder, one bit wider than WIDTH
    logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;  // accepted divisor was zero
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;

    assign trial = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    sub_17 #(.N(WIDTH + 1)) u_sub (
        .a      (trial),
        .b      ({1'b0, dvs_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    // Restore (keep trial) when the subtract borrows; the quotient bit is !borrow.
    assign r_step = borrow ? trial : diff;
    assign q_step = {q_q[WIDTH-2:0], ~borrow};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    r_d     = '0;
                    q_d     = dividend;
                    dvs_d   = divisor;
                    cnt_d   = CNT_W'(WIDTH);
                    zero_d  = (divisor == '0);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (zero_q) begin
                    // Zero divisor spends exactly one cycle here before DONE.
                    quo_d   = '1;
                    rem_d   = q_q;
                    dbz_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    r_d   = r_step;
                    q_d   = q_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        quo_d   = q_step;
                        rem_d   = r_step[WIDTH-1:0];
                        dbz_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign state_dbg   = state_q;

endmodule
